// File: rtl/rc5_key_expand.sv
// rc5_key_expand: RC5-16/r/16 key schedule, expands a 128-bit key into S[0..t-1].
// One S/L mixing update per clock; S is readable combinationally at any time.
`default_nettype none

module rc5_key_expand #(
  parameter int W     = 16,
  parameter int C     = 8,
  parameter int T_MAX = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    num_rounds,
  input  logic [127:0]  key,
  output logic          busy,
  output logic          done,
  output logic          key_valid,
  output logic [5:0]    t_out,
  input  logic [4:0]    s_raddr,
  output logic [15:0]   s_rdata
);

  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [W-1:0] s_mem [T_MAX];
  logic [W-1:0] l_mem [C];

  logic [4:0]   idx;
  logic [W-1:0] acc;
  logic [W-1:0] a_reg, b_reg;
  logic [4:0]   i_idx;
  logic [2:0]   j_idx;
  logic [6:0]   cnt;
  logic [5:0]   t_len;
  logic         kv_reg;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [3:0] n);
    logic [2*W-1:0] d;
    d = {x, x} << n;
    return d[2*W-1:W];
  endfunction

  logic [3:0]   r_eff;
  logic [5:0]   t_new;
  logic [6:0]   m_tot;
  logic         last_init;
  logic [W-1:0] a_new, ab_sum, b_new;
  logic [5:0]   i_inc;
  logic [4:0]   i_next;

  always_comb begin
    r_eff     = num_rounds[4] ? 4'd15 : num_rounds[3:0];
    t_new     = {1'b0, r_eff, 1'b0} + 6'd2;
    // Mixing pass count is 3*max(t, C); t < 8 only for r = 0..2.
    m_tot     = (t_len > 6'd8) ? ({1'b0, t_len} * 7'd3) : 7'd24;
    last_init = ({1'b0, idx} == (t_len - 6'd1));
    a_new     = rotl(s_mem[i_idx] + a_reg + b_reg, 4'd3);
    ab_sum    = a_new + b_reg;
    b_new     = rotl(l_mem[j_idx] + ab_sum, ab_sum[3:0]);
    i_inc     = {1'b0, i_idx} + 6'd1;
    i_next    = (i_inc == t_len) ? 5'd0 : i_inc[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = INIT;
      INIT: begin
        busy = 1'b1;
        if (last_init) state_next = MIX;
      end
      MIX: begin
        busy = 1'b1;
        if (cnt == 7'd0) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_len  <= 6'd0;
      kv_reg <= 1'b0;
      idx    <= 5'd0;
      acc    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      i_idx  <= 5'd0;
      j_idx  <= 3'd0;
      cnt    <= 7'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          t_len  <= t_new;
          kv_reg <= 1'b0;
          idx    <= 5'd0;
          acc    <= P16;
          a_reg  <= '0;
          b_reg  <= '0;
          i_idx  <= 5'd0;
          j_idx  <= 3'd0;
        end
        INIT: begin
          idx <= idx + 5'd1;
          acc <= acc + Q16;
          if (last_init) cnt <= m_tot - 7'd1;
        end
        MIX: begin
          a_reg <= a_new;
          b_reg <= b_new;
          i_idx <= i_next;
          j_idx <= j_idx + 3'd1;
          cnt   <= cnt - 7'd1;
          if (cnt == 7'd0) kv_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Table storage is never cleared; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && start) begin
        for (int k = 0; k < C; k++) l_mem[k] <= key[k*W +: W];
      end
      if (state == INIT) s_mem[idx] <= acc;
      if (state == MIX) begin
        s_mem[i_idx] <= a_new;
        l_mem[j_idx] <= b_new;
      end
    end
  end

  assign key_valid = kv_reg;
  assign t_out     = t_len;
  assign s_rdata   = s_mem[s_raddr];

endmodule

`default_nettype wire

// File: tb/tb_rc5_key_expand.sv
// Scoreboard bench for rc5_key_expand: expected tables from a software RC5 key
// schedule are queued at each start and compared by a monitor when done pulses.
`default_nettype none

module tb_rc5_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   num_rounds = 5'd0;
  logic [127:0] key = '0;
  logic         busy, done, key_valid;
  logic [5:0]   t_out;
  logic [4:0]   s_raddr;
  logic [4:0]   raddr_stim = 5'd0;
  logic [4:0]   raddr_mon = 5'd0;
  logic         mon_active = 1'b0;
  logic [15:0]  s_rdata;

  assign s_raddr = mon_active ? raddr_mon : raddr_stim;

  rc5_key_expand dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rounds (num_rounds),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .key_valid  (key_valid),
    .t_out      (t_out),
    .s_raddr    (s_raddr),
    .s_rdata    (s_rdata)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int n_checked_runs = 0;

  typedef struct packed {
    logic [511:0] s;
    logic [31:0]  t;
    logic [31:0]  lat;
    logic [31:0]  start_cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
    int s;
    s = n % 16;
    return (x << s) | (x >> (16 - s));
  endfunction

  // Textbook RC5 key schedule on plain arrays.
  function automatic logic [511:0] model(input logic [127:0] k, input int r);
    logic [15:0]  S[32];
    logic [15:0]  L[8];
    logic [15:0]  A, B, sum;
    logic [511:0] res;
    int t, n, i, j;
    if (r > 15) r = 15;
    t = 2 * (r + 1);
    for (int q = 0; q < 8; q++) L[q] = k[16*q +: 16];
    S[0] = 16'hB7E1;
    for (int q = 1; q < t; q++) S[q] = S[q-1] + 16'h9E37;
    A = 0; B = 0; i = 0; j = 0;
    n = 3 * ((t > 8) ? t : 8);
    for (int q = 0; q < n; q++) begin
      sum  = S[i] + A + B;
      A    = rotl16(sum, 3);
      S[i] = A;
      sum  = A + B;
      B    = rotl16(L[j] + sum, int'(sum));
      L[j] = B;
      i    = (i + 1) % t;
      j    = (j + 1) % 8;
    end
    res = '0;
    for (int q = 0; q < t; q++) res[16*q +: 16] = S[q];
    return res;
  endfunction

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic do_start(input logic [127:0] k, input logic [4:0] r, input bit push);
    exp_t e;
    int   ri, t;
    key        = k;
    num_rounds = r;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      ri = (int'(r) > 15) ? 15 : int'(r);
      t  = 2 * (ri + 1);
      e.s         = model(k, int'(r));
      e.t         = t;
      e.lat       = t + 3 * ((t > 8) ? t : 8);
      e.start_cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_runs(input int target, input int budget);
    int n;
    n = 0;
    while (n_checked_runs < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n_checked_runs < target) begin
      check("run_timeout", n_checked_runs, target);
      exp_q.delete();
      n_checked_runs = target;
    end
  endtask

  task automatic read_s(input logic [4:0] a, input logic [15:0] expv, input string name);
    raddr_stim = a;
    #1;
    check(name, s_rdata, expv);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc - e.start_cyc, e.lat);
          check("t_out", t_out, e.t);
          check("busy_at_done", busy, 0);
          check("key_valid_at_done", key_valid, 1);
          mon_active = 1'b1;
          for (int k = 0; k < e.t; k++) begin
            raddr_mon = k[4:0];
            #1;
            check($sformatf("S[%0d] t=%0d", k, e.t), s_rdata, e.s[16*k +: 16]);
          end
          mon_active = 1'b0;
          n_checked_runs++;
        end
      end
    end
  end

  initial begin
    int runs;
    runs = 0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_key_valid", key_valid, 0);
      check("idle_t_out", t_out, 0);
    end

    // Zero key, r=12: inspect INIT contents, first MIX step, then an ignored start.
    do_start(128'h0, 5'd12, 1'b1);
    runs++;
    check("busy_after_start", busy, 1);
    repeat (26) @(posedge clk);
    #1;
    check("t_out_r12", t_out, 26);
    read_s(5'd0,  16'hB7E1, "init_S0");
    read_s(5'd1,  16'h5618, "init_S1");
    read_s(5'd2,  16'hF44F, "init_S2");
    read_s(5'd25, 16'h2B40, "init_S25");
    @(posedge clk);
    #1;
    read_s(5'd0, 16'hBF0D, "mix1_S0");
    repeat (10) @(posedge clk);
    #1;
    do_start({$urandom, $urandom, $urandom, $urandom}, 5'd3, 1'b0);
    wait_runs(runs, 300);
    repeat (3) @(posedge clk);
    #1;
    check("key_valid_held", key_valid, 1);
    check("busy_after_done", busy, 0);
    check("t_out_held", t_out, 26);

    do_start({$urandom, $urandom, $urandom, $urandom}, 5'd1, 1'b1);
    runs++;
    wait_runs(runs, 200);

    // Random keys across every round count, plus clamped values above 15.
    for (int r = 0; r < 18; r++) begin
      for (int n = 0; n < 4; n++) begin
        logic [4:0] rr;
        rr = (r == 16) ? 5'd20 : (r == 17) ? 5'd31 : 5'(r);
        do_start({$urandom, $urandom, $urandom, $urandom}, rr, 1'b1);
        runs++;
        wait_runs(runs, 300);
      end
    end

    // Reset in the middle of MIX abandons the run.
    do_start({$urandom, $urandom, $urandom, $urandom}, 5'd12, 1'b1);
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_t_out", t_out, 0);
    end
    do_start(128'h00010002000300040005000600070008, 5'd5, 1'b1);
    runs++;
    wait_runs(runs, 200);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
